// File: rtl/mac_pp_accumulator.sv
// mac_pp_accumulator
//   Reduces the partial products of each multiplier in a vector to a signed
//   product and accumulates MULS_PER_BEAT products per clock into a wide
//   two's-complement accumulator. Vectors are chained with first/last framing
//   to form a dot product, and the result leaves on a valid/ready output.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   pp_i         partial products; multiplier m owns m*PP_PER_MUL +: PP_PER_MUL
//   pp_valid_i   pp_i valid
//   pp_first_i   vector starts a new accumulation
//   pp_last_i    vector ends the accumulation
//   pp_ready_o   block accepts a vector
//   acc_o        signed accumulated result
//   acc_valid_o  acc_o valid
//   acc_ready_i  downstream accepts acc_o
//   busy_o       high whenever the FSM is not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a vector; pp_ready_o high
// ACCUM | adding MULS_PER_BEAT products per clock from the captured vector
// OUT   | result presented on acc_o until acc_ready_i
module mac_pp_accumulator #(
    parameter int IN_SIZE_0     = 4,
    parameter int IN_SIZE_1     = 8,
    parameter int ARRAY_SIZE    = 8,
    parameter int MULS_PER_BEAT = 2,
    parameter int ACC_SIZE      = 32,
    localparam int PP_PER_MUL   = (IN_SIZE_1 + 2) / 3,
    localparam int PP_PER_ARRAY = PP_PER_MUL * ARRAY_SIZE,
    localparam int PP_SIZE      = IN_SIZE_0 + IN_SIZE_1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [PP_SIZE-1:0]  pp_i [0:PP_PER_ARRAY-1],
    input  logic                pp_valid_i,
    input  logic                pp_first_i,
    input  logic                pp_last_i,
    output logic                pp_ready_o,
    output logic [ACC_SIZE-1:0] acc_o,
    output logic                acc_valid_o,
    input  logic                acc_ready_i,
    output logic                busy_o
);

    localparam int BEATS     = ARRAY_SIZE / MULS_PER_BEAT;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_q, last_d;
    logic                pp_ready_q, pp_ready_d;
    logic                acc_valid_q, acc_valid_d;
    logic                busy_q, busy_d;
    logic [PP_SIZE-1:0]  pp_q [0:PP_PER_ARRAY-1];
    logic [PP_SIZE-1:0]  pp_d [0:PP_PER_ARRAY-1];
    logic [ACC_SIZE-1:0] beat_sum;

    // Sum of the products owned by the current beat. Each product is the
    // partial-product sum wrapped to PP_SIZE bits, then sign-extended.
    always_comb begin
        logic [PP_SIZE-1:0] prod;
        int                 m;
        beat_sum = '0;
        prod     = '0;
        m        = 0;
        for (int k = 0; k < MULS_PER_BEAT; k++) begin
            m    = int'(beat_q) * MULS_PER_BEAT + k;
            prod = '0;
            for (int j = 0; j < PP_PER_MUL; j++) begin
                prod = prod + pp_q[m*PP_PER_MUL + j];
            end
            beat_sum = beat_sum + ACC_SIZE'($signed(prod));
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        last_d  = last_q;
        pp_d    = pp_q;
        case (state_q)
            IDLE: begin
                if (pp_valid_i) begin
                    pp_d    = pp_i;
                    last_d  = pp_last_i;
                    beat_d  = '0;
                    state_d = ACCUM;
                    if (pp_first_i) begin
                        acc_d = '0;
                    end
                end
            end
            ACCUM: begin
                acc_d = acc_q + beat_sum;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = last_q ? OUT : IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            OUT: begin
                if (acc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pp_ready_d  = (state_d == IDLE);
        acc_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            last_q      <= 1'b0;
            pp_ready_q  <= 1'b1;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            pp_ready_q  <= pp_ready_d;
            acc_valid_q <= acc_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Vector buffer carries no reset: its contents are only read in ACCUM,
    // and reset always returns the FSM to IDLE, so stale data is discarded.
    always_ff @(posedge clk_i) begin
        pp_q <= pp_d;
    end

    assign pp_ready_o  = pp_ready_q;
    assign acc_valid_o = acc_valid_q;
    assign busy_o      = busy_q;
    assign acc_o       = acc_q;

endmodule

// File: tb/tb_mac_pp_accumulator.sv
module tb_mac_pp_accumulator;

    localparam int PPM = 3;
    localparam int NMUL = 8;
    localparam int NPP = PPM * NMUL;

    logic        clk;
    logic        rst_n;
    logic [11:0] pp1 [0:NPP-1];
    logic [11:0] pp2 [0:NPP-1];
    logic        pv1, pf1, pl1, ar1;
    logic        pv2, pf2, pl2, ar2;
    logic        prdy1, aval1, busy1;
    logic        prdy2, aval2, busy2;
    logic [31:0] acc1;
    logic [11:0] acc2;

    int total = 0;
    int bad   = 0;

    mac_pp_accumulator dut1 (
        .clk_i(clk), .rst_ni(rst_n), .pp_i(pp1), .pp_valid_i(pv1),
        .pp_first_i(pf1), .pp_last_i(pl1), .pp_ready_o(prdy1),
        .acc_o(acc1), .acc_valid_o(aval1), .acc_ready_i(ar1), .busy_o(busy1)
    );

    mac_pp_accumulator #(.ACC_SIZE(12)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .pp_i(pp2), .pp_valid_i(pv2),
        .pp_first_i(pf2), .pp_last_i(pl2), .pp_ready_o(prdy2),
        .acc_o(acc2), .acc_valid_o(aval2), .acc_ready_i(ar2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Split each lane's product a*b into three random partial products whose
    // 12-bit sum equals the product, so the reduction itself is exercised.
    task automatic fill(input int a, input int b, input bit which);
        logic [11:0] prod, r1, r2;
        for (int m = 0; m < NMUL; m++) begin
            prod = 12'(a * b);
            r1   = 12'($urandom);
            r2   = 12'($urandom);
            if (!which) begin
                pp1[m*PPM]   = prod - r1 - r2;
                pp1[m*PPM+1] = r1;
                pp1[m*PPM+2] = r2;
            end else begin
                pp2[m*PPM]   = prod - r1 - r2;
                pp2[m*PPM+1] = r1;
                pp2[m*PPM+2] = r2;
            end
        end
    endtask

    // Present one vector to dut1 while it is idle; scramble pp after accept.
    task automatic send(input int a, input int b, input bit f, input bit l);
        fill(a, b, 1'b0);
        pv1 = 1'b1; pf1 = f; pl1 = l;
        step();
        pv1 = 1'b0; pf1 = 1'b0; pl1 = 1'b0;
        fill(5, -3, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!aval1 && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'd0, aval1}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        pv1 = 0; pf1 = 0; pl1 = 0; ar1 = 0;
        pv2 = 0; pf2 = 0; pl2 = 0; ar2 = 0;
        fill(0, 0, 1'b0);
        fill(0, 0, 1'b1);
        step();
        step();
        check("rst_pp_ready", {31'd0, prdy1}, 32'd1);
        check("rst_acc_valid", {31'd0, aval1}, 32'd0);
        check("rst_acc", acc1, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: a=1,b=1 single vector, latency of 4 edges after accept
        send(1, 1, 1'b1, 1'b1);
        check("t1_ready_after_accept", {31'd0, prdy1}, 32'd0);
        check("t1_busy", {31'd0, busy1}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("t1_no_valid_e%0d", i), {31'd0, aval1}, 32'd0);
            check($sformatf("t1_no_ready_e%0d", i), {31'd0, prdy1}, 32'd0);
        end
        step();
        check("t1_valid_e4", {31'd0, aval1}, 32'd1);
        check("t1_acc", acc1, 32'd8);
        check("t1_ready_in_out", {31'd0, prdy1}, 32'd0);
        ar1 = 1'b1;
        step();
        ar1 = 1'b0;
        check("t1_valid_drop", {31'd0, aval1}, 32'd0);
        check("t1_ready_back", {31'd0, prdy1}, 32'd1);
        check("t1_idle", {31'd0, busy1}, 32'd0);

        // 2: a=-8,b=-128 -> 1024 per lane
        send(-8, -128, 1'b1, 1'b1);
        wait_valid("t2_valid");
        check("t2_acc", acc1, 32'd8192);

        // 4: backpressure on the test-2 result
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_acc_hold", acc1, 32'd8192);
            check("t4_valid_hold", {31'd0, aval1}, 32'd1);
            check("t4_ready_low", {31'd0, prdy1}, 32'd0);
        end
        ar1 = 1'b1;
        step();
        ar1 = 1'b0;
        check("t4_valid_drop", {31'd0, aval1}, 32'd0);
        check("t4_ready_back", {31'd0, prdy1}, 32'd1);

        // 3: chain A(3*5, first) + B(-2*7, last); B held valid during A
        fill(3, 5, 1'b0);
        pv1 = 1'b1; pf1 = 1'b1; pl1 = 1'b0;
        step();
        fill(-2, 7, 1'b0);
        pf1 = 1'b0; pl1 = 1'b1;
        check("t3_ready_low_a", {31'd0, prdy1}, 32'd0);
        step(); step(); step();
        check("t3_ready_low_e3", {31'd0, prdy1}, 32'd0);
        step();
        check("t3_ready_after_a", {31'd0, prdy1}, 32'd1);
        check("t3_no_valid_after_a", {31'd0, aval1}, 32'd0);
        check("t3_partial_a", acc1, 32'd120);
        step();
        pv1 = 1'b0; pl1 = 1'b0;
        fill(5, -3, 1'b0);
        check("t3_b_accepted", {31'd0, prdy1}, 32'd0);
        wait_valid("t3_valid");
        check("t3_acc", acc1, 32'd8);
        ar1 = 1'b1;
        step();
        ar1 = 1'b0;

        // 5: reset in the middle of a vector
        send(3, 3, 1'b1, 1'b1);
        step(); step();
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", {31'd0, prdy1}, 32'd1);
        check("t5_rst_valid", {31'd0, aval1}, 32'd0);
        check("t5_rst_acc", acc1, 32'd0);
        check("t5_rst_busy", {31'd0, busy1}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send(1, 1, 1'b1, 1'b1);
        wait_valid("t5_valid");
        check("t5_acc", acc1, 32'd8);
        ar1 = 1'b1;
        step();
        ar1 = 1'b0;

        // Non-first vector after reset adds onto 0; acc_ready held high
        // throughout, so it must be ignored until the result appears.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ar1 = 1'b1;
        step();
        send(2, 3, 1'b0, 1'b1);
        step(); step(); step();
        check("t7_no_early_valid", {31'd0, aval1}, 32'd0);
        step();
        check("t7_valid", {31'd0, aval1}, 32'd1);
        check("t7_acc", acc1, 32'd48);
        step();
        ar1 = 1'b0;
        check("t7_valid_drop", {31'd0, aval1}, 32'd0);

        // 6: 12-bit accumulator wraps: 8*889 = 7112 -> 12'hBC8
        check("t6_rst_ready", {31'd0, prdy2}, 32'd1);
        fill(7, 127, 1'b1);
        pv2 = 1'b1; pf2 = 1'b1; pl2 = 1'b1;
        step();
        pv2 = 1'b0; pf2 = 1'b0; pl2 = 1'b0;
        fill(5, -3, 1'b1);
        step(); step(); step(); step();
        check("t6_valid", {31'd0, aval2}, 32'd1);
        check("t6_acc", {20'd0, acc2}, 32'h0000_0BC8);
        ar2 = 1'b1;
        step();
        ar2 = 1'b0;
        check("t6_valid_drop", {31'd0, aval2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_pp_accumulator.md
Name: mac_pp_accumulator

Overview:
- Consumes the partial-product vector from the multsigned_array stage: ARRAY_SIZE multipliers, PP_PER_MUL partial products each.
- Reduces each multiplier's partial products to a signed product and adds MULS_PER_BEAT products per clock into a wide accumulator.
- Chains accumulation across successive vectors (first/last framing) to form a dot product.
- Emits the result on a valid/ready output toward the AI-core writeback.

Parameters:
- IN_SIZE_0, 4, operand-0 width (matches upstream).
- IN_SIZE_1, 8, operand-1 width (matches upstream).
- ARRAY_SIZE, 8, multipliers per vector.
- MULS_PER_BEAT, 2, products reduced per cycle; must divide ARRAY_SIZE.
- ACC_SIZE, 32, accumulator width; must be >= PP_SIZE.
- PP_PER_MUL, (IN_SIZE_1+2)/3, internal: partial products per multiplier.
- PP_PER_ARRAY, PP_PER_MUL*ARRAY_SIZE, internal: partial products per vector.
- PP_SIZE, IN_SIZE_0+IN_SIZE_1, internal: partial-product width.
- BEATS, ARRAY_SIZE/MULS_PER_BEAT, internal: cycles per vector.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- pp_i  in  [PP_SIZE-1:0] x [0:PP_PER_ARRAY-1]  partial products; multiplier m owns indices m*PP_PER_MUL .. m*PP_PER_MUL+PP_PER_MUL-1.
- pp_valid_i  in  1  pp_i valid.
- pp_first_i  in  1  vector starts a new accumulation; accumulator treated as 0 before it.
- pp_last_i  in  1  vector ends the accumulation; result is emitted after it.
- pp_ready_o  out  1  block accepts a vector.
- acc_o  out  ACC_SIZE  signed accumulated result.
- acc_valid_o  out  1  acc_o valid.
- acc_ready_i  in  1  downstream accepts acc_o.
- busy_o  out  1  high when state != IDLE.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, acc=0, beat counter=0, captured flags=0.
- Reset output values: pp_ready_o=1, acc_valid_o=0, acc_o=0, busy_o=0.
- Reset asserted mid-operation discards the buffered vector and any partial sum.
- Product rule: product[m] = sum of its PP_PER_MUL partial products mod 2^PP_SIZE, read as signed PP_SIZE, sign-extended to ACC_SIZE.
- Accumulator arithmetic: two's complement, wraps mod 2^ACC_SIZE, no saturation or flag.
- FSM IDLE: pp_ready_o=1. On pp_valid_i&pp_ready_o at edge E0:
  - register the full pp_i vector, pp_first_i and pp_last_i;
  - if first, clear acc to 0 at E0;
  - go to ACCUM, beat=0.
  - pp_i may change freely after E0.
- FSM ACCUM: pp_ready_o=0. At each edge, add products beat*MULS_PER_BEAT .. +MULS_PER_BEAT-1 to acc, then beat++.
  - The add at edge E_BEATS is the final one; beat wraps to 0.
  - Then go to OUT if last, else IDLE (pp_ready_o=1 again after E_BEATS).
- FSM OUT: acc_valid_o=1; acc_o=acc, held stable until acc_ready_i.
  - On acc_valid_o&acc_ready_i: go to IDLE, acc_valid_o=0 next cycle, acc retained (cleared by next first).
- Latency: acc_valid_o visible in the cycle after E_BEATS (BEATS edges after the accept edge).
- Throughput: one vector per BEATS+1 cycles without backpressure.
- First and last on the same vector: single-vector result.
- first while a chain is open: prior partial sum discarded.
- Non-first vector after reset: adds onto acc=0.
- acc_ready_i outside OUT: ignored.
- pp_valid_i while pp_ready_o=0: not consumed; upstream holds it.

Test Plan (defaults, BEATS=4; pp_i generated by a multsigned_array instance):
1. All lanes a=1,b=1, first=last=1 -> acc_valid_o rises 4 edges after accept, acc_o=8, pp_ready_o=0 until output handshake.
2. All lanes a=-8,b=-128, first=last=1 -> acc_o=8192 (product 1024 per lane).
3. Chain: vector A a=3,b=5, first=1 last=0; then vector B a=-2,b=7, first=0 last=1 -> no acc_valid_o after A; pp_ready_o=1 after A's 4th beat; final acc_o=8.
4. Backpressure: hold acc_ready_i=0 for 10 cycles in OUT -> acc_o constant, acc_valid_o=1, pp_ready_o=0; release -> acc_valid_o=0 and pp_ready_o=1 next cycle.
5. Pull rst_ni low after beat 2 of a vector -> all outputs at reset values immediately; a fresh a=1,b=1 first/last vector -> acc_o=8.
6. ACC_SIZE=12, all lanes a=7,b=127, first=last=1 -> acc_o=12'hBC8 (7112 mod 4096, signed -1080).
